// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 hex keypad scanner with debounce and 4-digit entry.
// Define KEYPAD_REPEAT_EN to auto-repeat a held key every REPEAT_CNT samples.
module keypad_scanner #(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 4,
   parameter int REPEAT_CNT   = 100
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [3:0]  Row,
   input  logic        Clear,
   output logic [3:0]  Col,
   output logic [3:0]  KeyCode,
   output logic        KeyValid,
   output logic [15:0] Value
);

   localparam int DW   = $clog2(SCAN_DIV);
   localparam int CMAX = (REPEAT_CNT > DEBOUNCE_CNT) ? REPEAT_CNT : DEBOUNCE_CNT;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CNT);
`ifdef KEYPAD_REPEAT_EN
   localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CNT);
`endif

   typedef enum logic [1:0] {SCAN, DEBOUNCE, ACCEPT, HELD} state_t;

   state_t        state, state_nxt;
   logic [3:0]    row_m, row_s;
   logic [DW-1:0] div;
   logic [1:0]    col_idx, col_nxt;
   logic [1:0]    row_idx;
   logic [1:0]    cand_row, cand_row_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [3:0]    code;
   logic          sample, pressed, same, accept;
`ifdef KEYPAD_REPEAT_EN
   logic [CW-1:0] rep, rep_nxt;
`endif

   assign sample  = (div == DIV_LAST);
   assign pressed = (row_s != 4'hF);
   assign same    = pressed && (row_idx == cand_row);
   assign code    = {cand_row_nxt, col_idx};
   assign Col     = ~(4'b0001 << col_idx);

   always_comb begin
      row_idx = 2'd3;
      if (!row_s[0])      row_idx = 2'd0;
      else if (!row_s[1]) row_idx = 2'd1;
      else if (!row_s[2]) row_idx = 2'd2;
   end

   // cnt is the debounce count in DEBOUNCE and the release count in HELD
   always_comb begin
      state_nxt    = state;
      col_nxt      = col_idx;
      cand_row_nxt = cand_row;
      cnt_nxt      = cnt;
      accept       = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_nxt      = rep;
`endif
      unique case (state)
         SCAN: begin
            if (sample) begin
               if (!pressed) begin
                  col_nxt = col_idx + 1'b1;
               end else begin
                  cand_row_nxt = row_idx;
                  if (DEBOUNCE_CNT == 1) begin
                     accept    = 1'b1;
                     state_nxt = ACCEPT;
                     cnt_nxt   = '0;
                  end else begin
                     state_nxt = DEBOUNCE;
                     cnt_nxt   = CW'(1);
                  end
               end
            end
         end
         DEBOUNCE: begin
            if (sample) begin
               if (!same) begin
                  state_nxt = SCAN;
                  col_nxt   = col_idx + 1'b1;
                  cnt_nxt   = '0;
               end else if (cnt + 1'b1 == DEB_LAST) begin
                  accept    = 1'b1;
                  state_nxt = ACCEPT;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         ACCEPT: begin
            state_nxt = HELD;
         end
         HELD: begin
            if (sample) begin
               if (pressed) begin
                  cnt_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
                  if (!same) begin
                     rep_nxt = '0;
                  end else if (rep + 1'b1 == REP_LAST) begin
                     accept    = 1'b1;
                     state_nxt = ACCEPT;
                     rep_nxt   = '0;
                  end else begin
                     rep_nxt = rep + 1'b1;
                  end
`endif
               end else begin
`ifdef KEYPAD_REPEAT_EN
                  rep_nxt = '0;
`endif
                  if (cnt + 1'b1 == DEB_LAST) begin
                     state_nxt = SCAN;
                     col_nxt   = col_idx + 1'b1;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt + 1'b1;
                  end
               end
            end
         end
         default: state_nxt = SCAN;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         row_m    <= 4'hF;
         row_s    <= 4'hF;
         div      <= '0;
         state    <= SCAN;
         col_idx  <= '0;
         cand_row <= '0;
         cnt      <= '0;
`ifdef KEYPAD_REPEAT_EN
         rep      <= '0;
`endif
         KeyValid <= 1'b0;
         KeyCode  <= 4'h0;
         Value    <= 16'h0000;
      end else begin
         row_m    <= Row;
         row_s    <= row_m;
         div      <= sample ? '0 : div + 1'b1;
         state    <= state_nxt;
         col_idx  <= col_nxt;
         cand_row <= cand_row_nxt;
         cnt      <= cnt_nxt;
`ifdef KEYPAD_REPEAT_EN
         rep      <= rep_nxt;
`endif
         KeyValid <= accept;
         if (accept)
            KeyCode <= code;
         // Clear landing on an accept keeps the freshly accepted digit
         if (accept)
            Value <= Clear ? {12'h000, code} : {Value[11:0], code};
         else if (Clear)
            Value <= (state == ACCEPT) ? {12'h000, KeyCode} : 16'h0000;
      end
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 membrane hex keypad and turns debounced key presses into 4-bit hex codes plus a 16-bit four-digit entry register. It is the input-side counterpart of the board's multiplexed four-digit 7-segment display path: the display path drives digits out, this block collects digits in. `Value` is sized to feed the CPU input registers or the display's 16-bit digit inputs directly. It runs on the undivided board clock.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per column slot; must be ≥ 4.
- `DEBOUNCE_CNT`, default 4: consecutive agreeing samples required to accept a press or a release; must be ≥ 1.
- `REPEAT_CNT`, default 100: held samples between auto-repeats. Used only when `KEYPAD_REPEAT_EN` is defined.
- `Clk` input, 1 bit: system clock, rising edge.
- `Reset` input, 1 bit: asynchronous reset, active-low.
- `Row` input, 4 bits: keypad rows, active-low (pulled up). Asynchronous to `Clk`.
- `Clear` input, 1 bit: synchronous clear of `Value`.
- `Col` output, 4 bits: one-hot-low column drive.
- `KeyCode` output, 4 bits: code of the last accepted key.
- `KeyValid` output, 1 bit: one-cycle pulse per accepted key.
- `Value` output, 16 bits: last four accepted codes; newest code is in `[3:0]`.

## Operation
- **Row synchronisation:** `Row` passes through a 2-flop synchroniser. All decisions use the synchronised value `RowS`.
- **Column slots:**
  - A divider counts 0..`SCAN_DIV`-1.
  - The sample point is count = `SCAN_DIV`-1, which gives at least 3 cycles of settling.
  - `Col` = ~(1 << `col_idx`).
- **Key code:** `KeyCode` = 4*`row_idx` + `col_idx`.
  - `row_idx` is the lowest-numbered row whose `RowS` bit is 0.
  - If several rows are low, the lowest index wins.
- **FSM states:**
  - **SCAN**
    - At each sample point: if `RowS` is 4'hF, advance `col_idx` (3 wraps to 0).
    - Otherwise latch the candidate `{row_idx, col_idx}`, set the debounce count to 1, freeze the column, and go to DEBOUNCE.
  - **DEBOUNCE** (column frozen)
    - At each sample point: if the same candidate row is still the lowest low row, increment the count.
    - Otherwise go to SCAN and advance the column.
    - When the count reaches `DEBOUNCE_CNT`, go to ACCEPT. With `DEBOUNCE_CNT`=1, SCAN goes directly to ACCEPT.
  - **ACCEPT** (one cycle)
    - `KeyValid`=1 and `KeyCode` = candidate.
    - `Value` <= {`Value`[11:0], candidate}.
    - Go to HELD.
  - **HELD** (column frozen)
    - At each sample point: if `RowS` is 4'hF, increment the release count.
    - Any low row resets the release count to 0.
    - When the release count reaches `DEBOUNCE_CNT`, go to SCAN and advance the column.
- **Clear:**
  - `Value` <= 0 on any cycle where `Clear`=1.
  - If `Clear` and ACCEPT coincide, `Value` <= {12'h000, candidate}.
  - `Clear` never affects the FSM, `KeyCode` or `KeyValid`.
- **Reset mid-operation:** asynchronously returns everything to the reset values below. Any in-progress debounce is discarded.

## Timing
- **Reset values:**
  - `Col`=4'b1110, `KeyCode`=4'h0, `KeyValid`=0, `Value`=16'h0000.
  - FSM in SCAN, `col_idx`=0, all counters 0, synchroniser flops 4'hF.
- **Accept latency:** `KeyValid` rises on the cycle after the sample point that delivers the `DEBOUNCE_CNT`-th agreeing sample.
- **Output registering:** `KeyCode` and `Value` update on that same edge and hold until the next accept.
- **Minimum spacing:** two `KeyValid` pulses are separated by at least (2*`DEBOUNCE_CNT`)*`SCAN_DIV` cycles, unless auto-repeat is enabled.
- **Column change:** `Col` changes only on the cycle after a sample point.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - HELD also counts consecutive pressed samples of the same key.
  - On reaching `REPEAT_CNT`, it pulses `KeyValid` again with the same code, shifts `Value`, and resets the count.
  - A release sample resets the count.
- `KEYPAD_REPEAT_EN` undefined: there is no repeat logic; one pulse per press.

## Test plan
Parameters for the bench: `SCAN_DIV`=4, `DEBOUNCE_CNT`=3, `REPEAT_CNT`=5.
- **Idle scan:** `Row`=4'hF after reset → `Col` cycles 1110, 1101, 1011, 0111, 1110…, changing every 4 cycles; `KeyValid` never asserts.
- **Clean press:** hold row 2 low while col 1 is driven, for 30 cycles → one `KeyValid` pulse, `KeyCode`=4'h9, `Value`=16'h0009.
- **Bounce and digit entry:**
  - Row 2 toggles every 3 cycles during debounce → no pulse.
  - Then press keys 1, 2, 3, 4 cleanly → `Value`=16'h1234.
  - Then press 5 → `Value`=16'h2345.
- **Clear and accept together:** assert `Clear` on the ACCEPT cycle of key 7 → `Value`=16'h0007.
- **Two rows, reset:**
  - Rows 1 and 3 low on col 0 → `KeyCode`=4'h4.
  - Assert `Reset`=0 during DEBOUNCE → `Col`=4'b1110 immediately, `Value`=0, no pulse after release.
- **Auto-repeat:** with `KEYPAD_REPEAT_EN` defined, hold key A for 100 cycles → first pulse, then a repeat pulse every 20 cycles (`REPEAT_CNT`=5 samples × `SCAN_DIV`=4), each `KeyCode`=4'hA.
